cordic_ahb_master: RTL and testbench



---
 rtl/cordic_ahb_master_pkg.sv | 29 ++
 rtl/cordic_ahb_master_poll_timer.sv | 29 ++
 rtl/cordic_ahb_master.sv | 155 +++++++++++++++
 tb/tb_cordic_ahb_master.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_ahb_master_pkg.sv
// Shared AHB-Lite encodings, FSM state type and default CORDIC slave map
// for the cordic_ahb_master initiator.
package cordic_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  localparam logic [31:0] DEF_BASE_ADDR     = 32'h4000_0000;
  localparam logic [31:0] DEF_DATA_OFFSET   = 32'h0000_0000;
  localparam logic [31:0] DEF_STATUS_OFFSET = 32'h0000_0004;
  localparam logic [31:0] DEF_RESULT_OFFSET = 32'h0000_0008;

  localparam logic [31:0] TIMEOUT_SENTINEL = 32'hDEAD_0001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_A,
    ST_WR_D,
    ST_PL_A,
    ST_PL_D,
    ST_RD_A,
    ST_RD_D,
    ST_RESP
  } state_t;

endpackage

// File: rtl/cordic_ahb_master_poll_timer.sv
// Status-poll counter for cordic_ahb_master; only instantiated when
// CORDIC_POLL_TIMEOUT_EN is defined.
module cordic_poll_timer #(
  parameter int POLL_MAX = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_incr,
  output logic o_expired
);

  localparam int CW = (POLL_MAX < 1) ? 1 : $clog2(POLL_MAX + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_incr) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == CW'(POLL_MAX));

endmodule

// File: rtl/cordic_ahb_master.sv
// AHB-Lite initiator: per job writes the operand, polls status, reads the result.
// Optional bounded polling enabled by defining CORDIC_POLL_TIMEOUT_EN.
module cordic_ahb_master
  import cordic_ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = DEF_BASE_ADDR,
  parameter logic [31:0] DATA_OFFSET   = DEF_DATA_OFFSET,
  parameter logic [31:0] STATUS_OFFSET = DEF_STATUS_OFFSET,
  parameter logic [31:0] RESULT_OFFSET = DEF_RESULT_OFFSET
`ifdef CORDIC_POLL_TIMEOUT_EN
  , parameter int        POLL_MAX      = 255
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic [1:0]  HRESP
);

  localparam logic [31:0] ADDR_DATA   = BASE_ADDR + DATA_OFFSET;
  localparam logic [31:0] ADDR_STATUS = BASE_ADDR + STATUS_OFFSET;
  localparam logic [31:0] ADDR_RESULT = BASE_ADDR + RESULT_OFFSET;

  state_t r_state;
  logic   w_dataPhase;
  logic   w_busError;
  logic   w_pollExpired;
  logic   w_unused;

  assign HSIZE     = HSIZE_WORD;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DATA;
  assign HMASTLOCK = 1'b0;
  assign job_ready = (r_state == ST_IDLE);
  assign w_unused  = HRESP[1];

  assign w_dataPhase = (r_state == ST_WR_D) || (r_state == ST_PL_D) || (r_state == ST_RD_D);
  // Only the completing (HREADY=1) cycle of the two-cycle error response ends the job.
  assign w_busError  = w_dataPhase && HREADY && HRESP[0];

`ifdef CORDIC_POLL_TIMEOUT_EN
  logic w_pollIncr;
  logic w_pollClear;

  assign w_pollIncr  = (r_state == ST_PL_D) && HREADY && !HRESP[0] && !HRDATA[0] && !w_pollExpired;
  assign w_pollClear = (r_state == ST_RESP) && res_ready;

  cordic_poll_timer #(
    .POLL_MAX (POLL_MAX)
  ) u_pollTimer (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_pollClear),
    .i_incr    (w_pollIncr),
    .o_expired (w_pollExpired)
  );
`else
  assign w_pollExpired = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      HTRANS    <= HTRANS_IDLE;
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HWDATA    <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      res_err   <= 1'b0;
    end else if (w_busError) begin
      res_err   <= 1'b1;
      res_data  <= '0;
      res_valid <= 1'b1;
      r_state   <= ST_RESP;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (job_valid) begin
            HWDATA  <= job_data;
            HTRANS  <= HTRANS_NONSEQ;
            HADDR   <= ADDR_DATA;
            HWRITE  <= 1'b1;
            r_state <= ST_WR_A;
          end
        end
        ST_WR_A, ST_PL_A, ST_RD_A: begin
          if (HREADY) begin
            HTRANS  <= HTRANS_IDLE;
            r_state <= (r_state == ST_WR_A) ? ST_WR_D :
                       (r_state == ST_PL_A) ? ST_PL_D : ST_RD_D;
          end
        end
        ST_WR_D: begin
          if (HREADY) begin
            HTRANS  <= HTRANS_NONSEQ;
            HADDR   <= ADDR_STATUS;
            HWRITE  <= 1'b0;
            r_state <= ST_PL_A;
          end
        end
        ST_PL_D: begin
          if (HREADY) begin
            if (HRDATA[0]) begin
              HTRANS  <= HTRANS_NONSEQ;
              HADDR   <= ADDR_RESULT;
              r_state <= ST_RD_A;
            end else if (w_pollExpired) begin
              res_err   <= 1'b1;
              res_data  <= TIMEOUT_SENTINEL;
              res_valid <= 1'b1;
              r_state   <= ST_RESP;
            end else begin
              HTRANS  <= HTRANS_NONSEQ;
              HADDR   <= ADDR_STATUS;
              r_state <= ST_PL_A;
            end
          end
        end
        ST_RD_D: begin
          if (HREADY) begin
            res_data  <= HRDATA;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            r_state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_ahb_master.sv
// Directed bench for cordic_ahb_master with a scripted AHB-Lite slave model.
// Define CORDIC_POLL_TIMEOUT_EN to also exercise the poll timeout (POLL_MAX=3).
module tb_cordic_ahb_master;

   localparam logic [31:0] ADDR_DATA   = 32'h4000_0000;
   localparam logic [31:0] ADDR_STATUS = 32'h4000_0004;
   localparam logic [31:0] ADDR_RESULT = 32'h4000_0008;

   logic        clk = 1'b0;
   logic        reset;
   logic        job_valid;
   logic        job_ready;
   logic [31:0] job_data;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic        res_err;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic        HMASTLOCK;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic [1:0]  HRESP;

   // Slave-model configuration, written only by the main sequence
   int          statusOneAfter = 0;
   int          waitWrA        = 0;
   int          waitRdD        = 0;
   logic        errOnWrite     = 1'b0;
   logic [31:0] resultWord     = 32'h0;

   // Slave-model observations, written only by the model process
   int          writes      = 0;
   int          statusReads = 0;
   int          resultReads = 0;
   int          badAddr     = 0;
   int          stabErr     = 0;
   logic [31:0] lastWData   = 32'h0;

   logic        dataPhase;
   logic [31:0] dpAddr;
   logic        dpWrite;
   int          errStage;
   int          addrWaitCnt;
   int          dataWaitCnt;
   logic [1:0]  prevHTRANS;
   logic [31:0] prevHADDR;
   logic        prevHWRITE;
   logic [31:0] prevHWDATA;
   logic        prevHREADY;

   int testsRun  = 0;
   int failCount = 0;

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

`ifdef CORDIC_POLL_TIMEOUT_EN
   cordic_ahb_master #(.POLL_MAX(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .job_valid (job_valid),
      .job_ready (job_ready),
      .job_data  (job_data),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_err   (res_err),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HBURST    (HBURST),
      .HPROT     (HPROT),
      .HMASTLOCK (HMASTLOCK),
      .HWDATA    (HWDATA),
      .HRDATA    (HRDATA),
      .HREADY    (HREADY),
      .HRESP     (HRESP)
   );
`else
   cordic_ahb_master dut (
      .clk       (clk),
      .reset     (reset),
      .job_valid (job_valid),
      .job_ready (job_ready),
      .job_data  (job_data),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_err   (res_err),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HBURST    (HBURST),
      .HPROT     (HPROT),
      .HMASTLOCK (HMASTLOCK),
      .HWDATA    (HWDATA),
      .HRDATA    (HRDATA),
      .HREADY    (HREADY),
      .HRESP     (HRESP)
   );
`endif

   // Slave model: each negedge retires the previous cycle's transfer using
   // the saved bus values, checks wait-state stability, then drives this cycle.
   always @(negedge clk) begin
      if (reset) begin
         dataPhase   = 1'b0;
         errStage    = 0;
         addrWaitCnt = 0;
         dataWaitCnt = 0;
         HREADY      = 1'b1;
         HRESP       = 2'b00;
         HRDATA      = 32'h0;
      end else begin
         if (dataPhase && prevHREADY) begin
            dataPhase   = 1'b0;
            errStage    = 0;
            dataWaitCnt = 0;
            if (dpWrite && dpAddr == ADDR_DATA) begin
               writes++;
               lastWData = prevHWDATA;
            end else if (!dpWrite && dpAddr == ADDR_STATUS) statusReads++;
            else if (!dpWrite && dpAddr == ADDR_RESULT) resultReads++;
            else badAddr++;
         end
         if (prevHTRANS == 2'b10 && prevHREADY) begin
            dataPhase   = 1'b1;
            dpAddr      = prevHADDR;
            dpWrite     = prevHWRITE;
            addrWaitCnt = 0;
         end
         if (!prevHREADY && (HTRANS !== prevHTRANS || HADDR !== prevHADDR || HWDATA !== prevHWDATA))
            stabErr++;
         HRESP  = 2'b00;
         HRDATA = 32'h0;
         HREADY = 1'b1;
         if (dataPhase) begin
            if (dpWrite && errOnWrite) begin
               HRESP  = 2'b01;
               HREADY = (errStage == 1);
               errStage++;
            end else if (!dpWrite && dpAddr == ADDR_RESULT && dataWaitCnt < waitRdD) begin
               HREADY = 1'b0;
               dataWaitCnt++;
            end else if (!dpWrite && dpAddr == ADDR_STATUS) begin
               HRDATA = (statusReads >= statusOneAfter) ? 32'h0000_0001 : 32'hFFFF_FFFE;
            end else if (!dpWrite && dpAddr == ADDR_RESULT) begin
               HRDATA = resultWord;
            end
         end else if (HTRANS == 2'b10 && HWRITE && addrWaitCnt < waitWrA) begin
            HREADY = 1'b0;
            addrWaitCnt++;
         end
      end
      prevHTRANS = HTRANS;
      prevHADDR  = HADDR;
      prevHWRITE = HWRITE;
      prevHWDATA = HWDATA;
      prevHREADY = HREADY;
   end

   // Compares an observed value against the expected one and tallies failures
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Offers one job, measures cycles from acceptance to res_valid, holds
   // res_ready low for 'hold' cycles, then completes the result handshake.
   task automatic applyStimulus(input logic [31:0] data, input int hold,
                                output int lat, output logic [31:0] rData, output logic rErr);
      int cnt;
      int bad;
      checkOutput("job_ready before offer", 32'(job_ready), 32'd1);
      job_valid = 1'b1;
      job_data  = data;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
         job_valid = 1'b0;
      end while (!res_valid && cnt < 100);
      if (!res_valid) checkOutput("response timeout", 32'(res_valid), 32'd1);
      lat   = cnt;
      rData = res_data;
      rErr  = res_err;
      bad   = 0;
      repeat (hold) begin
         @(negedge clk);
         if (res_valid !== 1'b1 || res_data !== rData || res_err !== rErr || job_ready !== 1'b0) bad++;
      end
      if (hold > 0) checkOutput("result hold stable", 32'(bad), 32'd0);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      checkOutput("res_valid after handshake", 32'(res_valid), 32'd0);
   endtask

   // Watchdog against a hung simulation
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Main directed sequence
   initial begin
      int          lat;
      logic [31:0] rData;
      logic        rErr;
      int          w0, s0, r0, st0;

      reset     = 1'b1;
      job_valid = 1'b0;
      job_data  = 32'h0;
      res_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checkOutput("reset HTRANS", 32'(HTRANS), 32'd0);
      checkOutput("reset HADDR", HADDR, 32'h0);
      checkOutput("reset res_valid", 32'(res_valid), 32'd0);
      checkOutput("reset job_ready", 32'(job_ready), 32'd1);
      checkOutput("const HSIZE/HBURST/HPROT/HMASTLOCK",
                  32'({HSIZE, HBURST, HPROT, HMASTLOCK}), 32'({3'b010, 3'b000, 4'b0011, 1'b0}));

      $display("[TB] zero-wait job");
      w0 = writes; s0 = statusReads; r0 = resultReads;
      statusOneAfter = statusReads; resultWord = 32'hCAFE_0001;
      applyStimulus(32'h0000_1234, 0, lat, rData, rErr);
      checkOutput("zero-wait latency", 32'(lat), 32'd7);
      checkOutput("zero-wait res_data", rData, 32'hCAFE_0001);
      checkOutput("zero-wait res_err", 32'(rErr), 32'd0);
      checkOutput("zero-wait writes", 32'(writes - w0), 32'd1);
      checkOutput("zero-wait HWDATA", lastWData, 32'h0000_1234);
      checkOutput("zero-wait status reads", 32'(statusReads - s0), 32'd1);
      checkOutput("zero-wait result reads", 32'(resultReads - r0), 32'd1);

      $display("[TB] three not-ready polls");
      s0 = statusReads; r0 = resultReads;
      statusOneAfter = statusReads + 3; resultWord = 32'h1357_9BDF;
      applyStimulus(32'h0000_00A5, 0, lat, rData, rErr);
      checkOutput("poll latency", 32'(lat), 32'd13);
      checkOutput("poll status reads", 32'(statusReads - s0), 32'd4);
      checkOutput("poll result reads", 32'(resultReads - r0), 32'd1);
      checkOutput("poll res_data", rData, 32'h1357_9BDF);

      $display("[TB] wait states in WR_A and RD_D");
      st0 = stabErr;
      statusOneAfter = statusReads; resultWord = 32'h89AB_CDEF;
      waitWrA = 2; waitRdD = 3;
      applyStimulus(32'h7654_3210, 0, lat, rData, rErr);
      waitWrA = 0; waitRdD = 0;
      checkOutput("wait latency", 32'(lat), 32'd12);
      checkOutput("wait bus stability", 32'(stabErr - st0), 32'd0);
      checkOutput("wait HWDATA", lastWData, 32'h7654_3210);
      checkOutput("wait res_data", rData, 32'h89AB_CDEF);

      $display("[TB] error response on operand write");
      s0 = statusReads; r0 = resultReads;
      errOnWrite = 1'b1; statusOneAfter = statusReads; resultWord = 32'h1111_2222;
      applyStimulus(32'h0000_0BAD, 0, lat, rData, rErr);
      errOnWrite = 1'b0;
      checkOutput("error latency", 32'(lat), 32'd4);
      checkOutput("error res_err", 32'(rErr), 32'd1);
      checkOutput("error res_data", rData, 32'h0);
      checkOutput("error status reads", 32'(statusReads - s0), 32'd0);
      checkOutput("error result reads", 32'(resultReads - r0), 32'd0);
      statusOneAfter = statusReads; resultWord = 32'h0BAD_C0DE;
      applyStimulus(32'h0000_0042, 0, lat, rData, rErr);
      checkOutput("after-error latency", 32'(lat), 32'd7);
      checkOutput("after-error res_data", rData, 32'h0BAD_C0DE);
      checkOutput("after-error res_err", 32'(rErr), 32'd0);

      $display("[TB] consumer stalls result");
      statusOneAfter = statusReads; resultWord = 32'hA5A5_5A5A;
      applyStimulus(32'h0000_0077, 5, lat, rData, rErr);
      checkOutput("stall res_data", rData, 32'hA5A5_5A5A);

      $display("[TB] reset during status data phase");
      statusOneAfter = 32'h3FFF_FFFF;
      job_valid = 1'b1; job_data = 32'h0BAD_F00D;
      @(negedge clk);
      job_valid = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("pre-reset in PL_D HADDR", HADDR, ADDR_STATUS);
      checkOutput("pre-reset in PL_D HTRANS", 32'(HTRANS), 32'd0);
      #1 reset = 1'b1;
      #1;
      checkOutput("mid reset HADDR", HADDR, 32'h0);
      checkOutput("mid reset HWDATA", HWDATA, 32'h0);
      checkOutput("mid reset HWRITE/HTRANS", 32'({HWRITE, HTRANS}), 32'd0);
      checkOutput("mid reset res_data", res_data, 32'h0);
      checkOutput("mid reset res_valid/res_err", 32'({res_valid, res_err}), 32'd0);
      @(negedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      statusOneAfter = statusReads; resultWord = 32'h0F0F_F0F0;
      applyStimulus(32'h55AA_1234, 0, lat, rData, rErr);
      checkOutput("post-reset latency", 32'(lat), 32'd7);
      checkOutput("post-reset res_data", rData, 32'h0F0F_F0F0);

`ifdef CORDIC_POLL_TIMEOUT_EN
      $display("[TB] poll timeout");
      s0 = statusReads; r0 = resultReads;
      statusOneAfter = 32'h3FFF_FFFF;
      applyStimulus(32'h0000_0999, 0, lat, rData, rErr);
      checkOutput("timeout status reads", 32'(statusReads - s0), 32'd4);
      checkOutput("timeout result reads", 32'(resultReads - r0), 32'd0);
      checkOutput("timeout latency", 32'(lat), 32'd11);
      checkOutput("timeout res_err", 32'(rErr), 32'd1);
      checkOutput("timeout res_data", rData, 32'hDEAD_0001);
      statusOneAfter = statusReads; resultWord = 32'h2468_ACE0;
      applyStimulus(32'h0000_0111, 0, lat, rData, rErr);
      checkOutput("after-timeout res_data", rData, 32'h2468_ACE0);
`endif

      checkOutput("no unexpected addresses", 32'(badAddr), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
